// File: rtl/mod_updown_counter.sv
// mod_updown_counter: parametrised modulo-N up/down counter with load, saturate/wrap mode and cascade outputs
module mod_updown_counter #(
    parameter int              WIDTH    = 3,
    parameter longint unsigned MODULUS  = 8,
    parameter bit              SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_flag,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             wrapped_flag
);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 64'd1);
    if (WIDTH < 1 || WIDTH > 32 || MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_params
        $error("mod_updown_counter: illegal WIDTH/MODULUS combination");
    end
    logic             at_bnd;
    logic             step_wrap;
    logic [WIDTH-1:0] nxt;
    always_comb begin
        at_bnd    = up_dn ? count == MAX : count == '0;
        tc        = en & ~load & at_bnd;
        step_wrap = tc & ~SATURATE;
        nxt       = load   ? (load_val > MAX ? MAX : load_val)
                  : ~en    ? count
                  : at_bnd ? (SATURATE ? count : (up_dn ? '0 : MAX))
                  : up_dn  ? count + WIDTH'(1) : count - WIDTH'(1);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            count        <= '0;
            wrap         <= 1'b0;
            wrapped_flag <= 1'b0;
        end else begin
            count        <= nxt;
            wrap         <= step_wrap;
            wrapped_flag <= step_wrap | (wrapped_flag & ~clr_flag);
        end
    end
endmodule

// File: tb/tb_mod_updown_counter.sv
// tb_mod_updown_counter: randomized and directed checks of several counter configurations against a behavioural model
module tb_mod_updown_counter;
    localparam int N = 5;
    localparam int WS[N] = '{3, 4, 3, 4, 1};
    localparam int MS[N] = '{8, 10, 5, 16, 2};
    localparam bit SS[N] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    logic clk = 1'b0;
    logic rst = 1'b0, en = 1'b0, up_dn = 1'b1, load = 1'b0, clr = 1'b0;
    logic [3:0] lv = '0;
    logic [3:0] dc [N];
    logic dtc [N], dwr [N], dfl [N];
    logic [1:0] q1, q2;
    logic t1, t2, w1, w2, f1, f2;

    int nchk = 0, nerr = 0;
    int mc [N];
    bit mw [N], mf [N];
    int cv = 0;
    bit cw = 0, cf = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        logic [WS[g]-1:0] c;
        mod_updown_counter #(.WIDTH(WS[g]), .MODULUS(MS[g]), .SATURATE(SS[g])) dut (
            .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
            .load_val(lv[WS[g]-1:0]), .clr_flag(clr),
            .count(c), .tc(dtc[g]), .wrap(dwr[g]), .wrapped_flag(dfl[g])
        );
        assign dc[g] = 4'(c);
    end

    mod_updown_counter #(.WIDTH(2), .MODULUS(4), .SATURATE(1'b0)) s1 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(1'b0), .load_val(2'd0),
        .clr_flag(1'b0), .count(q1), .tc(t1), .wrap(w1), .wrapped_flag(f1)
    );
    mod_updown_counter #(.WIDTH(2), .MODULUS(4), .SATURATE(1'b0)) s2 (
        .clk(clk), .rst(rst), .en(t1), .up_dn(up_dn), .load(1'b0), .load_val(2'd0),
        .clr_flag(1'b0), .count(q2), .tc(t2), .wrap(w2), .wrapped_flag(f2)
    );

    task automatic cmp(input string name, input int got, input int exp);
        nchk++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < N; k++) begin
            cmp($sformatf("count[%0d]", k), int'(dc[k]), mc[k]);
            cmp($sformatf("tc[%0d]", k), int'(dtc[k]),
                int'(en && !load && (up_dn ? mc[k] == MS[k] - 1 : mc[k] == 0)));
            cmp($sformatf("wrap[%0d]", k), int'(dwr[k]), int'(mw[k]));
            cmp($sformatf("flag[%0d]", k), int'(dfl[k]), int'(mf[k]));
        end
        cmp("cascade value", int'({q2, q1}), cv);
        cmp("cascade tc1", int'(t1), int'(en && (up_dn ? cv % 4 == 3 : cv % 4 == 0)));
        cmp("cascade tc2", int'(t2), int'(en && (up_dn ? cv == 15 : cv == 0)));
        cmp("cascade wrap2", int'(w2), int'(cw));
        cmp("cascade flag2", int'(f2), int'(cf));
    endtask

    task automatic model_update();
        for (int k = 0; k < N; k++) begin
            int v, n;
            bit b;
            v = int'(lv) % (1 << WS[k]);
            if (rst) begin
                mc[k] = 0; mw[k] = 0; mf[k] = 0;
            end else if (load) begin
                mc[k] = v >= MS[k] ? MS[k] - 1 : v;
                mw[k] = 0;
                mf[k] = mf[k] && !clr;
            end else if (en) begin
                n = up_dn ? mc[k] + 1 : mc[k] - 1;
                b = n < 0 || n >= MS[k];
                mc[k] = !b ? n : SS[k] ? mc[k] : (n + MS[k]) % MS[k];
                mw[k] = b && !SS[k];
                mf[k] = mw[k] || (mf[k] && !clr);
            end else begin
                mw[k] = 0;
                mf[k] = mf[k] && !clr;
            end
        end
        if (rst) begin
            cv = 0; cw = 0; cf = 0;
        end else if (en) begin
            int n;
            n = up_dn ? cv + 1 : cv - 1;
            cw = n < 0 || n > 15;
            cv = (n + 16) % 16;
            cf = cf || cw;
        end else begin
            cw = 0;
        end
    endtask

    task automatic step(input bit r, input bit e, input bit u, input bit l, input logic [3:0] v, input bit c);
        @(negedge clk);
        rst = r; en = e; up_dn = u; load = l; lv = v; clr = c;
        @(posedge clk);
        model_update();
        #1 check_all();
    endtask

    initial begin
        bit dir;
        repeat (2) step(1, 0, 1, 0, 4'd0, 0);
        cmp("lit reset count0", int'(dc[0]), 0);
        cmp("lit reset flag0", int'(dfl[0]), 0);
        repeat (10) step(0, 1, 1, 0, 4'd0, 0);
        cmp("lit up10 count0", int'(dc[0]), 2);
        cmp("lit up10 flag0", int'(dfl[0]), 1);
        cmp("lit up10 count1", int'(dc[1]), 0);
        cmp("lit up10 sat count2", int'(dc[2]), 4);
        cmp("lit up10 sat flag2", int'(dfl[2]), 0);
        cmp("lit up10 cascade", int'({q2, q1}), 10);
        repeat (6) step(0, 1, 1, 0, 4'd0, 0);
        cmp("lit up16 count0", int'(dc[0]), 0);
        cmp("lit up16 wrap0", int'(dwr[0]), 1);
        cmp("lit up16 count3", int'(dc[3]), 0);
        cmp("lit up16 cascade", int'({q2, q1}), 0);
        cmp("lit up16 cascade wrap2", int'(w2), 1);
        step(1, 0, 0, 0, 4'd0, 0);
        step(0, 1, 0, 0, 4'd0, 0);
        cmp("lit down1 count1", int'(dc[1]), 9);
        cmp("lit down1 wrap1", int'(dwr[1]), 1);
        repeat (11) step(0, 1, 0, 0, 4'd0, 0);
        cmp("lit down12 count1", int'(dc[1]), 8);
        cmp("lit down12 sat count2", int'(dc[2]), 0);
        step(0, 1, 1, 1, 4'd6, 0);
        cmp("lit load6 count1", int'(dc[1]), 6);
        cmp("lit load6 wrap1", int'(dwr[1]), 0);
        step(0, 1, 1, 1, 4'd13, 0);
        cmp("lit load13 count1", int'(dc[1]), 9);
        cmp("lit load13 count0", int'(dc[0]), 5);
        step(0, 1, 1, 1, 4'd3, 0);
        cmp("lit load at max count1", int'(dc[1]), 3);
        cmp("lit load at max wrap1", int'(dwr[1]), 0);
        step(0, 0, 1, 1, 4'd7, 0);
        step(0, 1, 1, 0, 4'd0, 1);
        cmp("lit clr+wrap flag0", int'(dfl[0]), 1);
        step(0, 0, 1, 0, 4'd0, 1);
        cmp("lit clr later flag0", int'(dfl[0]), 0);
        step(0, 1, 1, 0, 4'd0, 0);
        step(1, 1, 1, 1, 4'd6, 0);
        cmp("lit mid rst count1", int'(dc[1]), 0);
        cmp("lit mid rst wrap1", int'(dwr[1]), 0);
        cmp("lit mid rst flag1", int'(dfl[1]), 0);
        dir = 1;
        for (int i = 0; i < 2000; i++) begin
            bit r, l, c;
            r = $urandom_range(63) == 0;
            l = $urandom_range(7) == 0;
            c = !l && $urandom_range(7) == 0;
            if ($urandom_range(15) == 0) dir = !dir;
            step(r, $urandom_range(3) != 0, dir, l, 4'($urandom_range(15)), c);
        end
        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end
endmodule
